// File: rtl/pila_retorno_pkg.sv
// Shared constants and push/pop decode for the return-address stack.
package pila_retorno_pkg;

  // PC width, shared with the PC register and the PC-increment adder.
  localparam int RET_WIDTH = 10;
  // Number of nested subroutine levels held in hardware.
  localparam int RET_DEPTH = 8;

  // One operation per cycle, resolved from the strobes and occupancy.
  typedef enum logic [2:0] {
    OP_HOLD       = 3'd0,  // no strobe
    OP_PUSH       = 3'd1,  // CALL with room left
    OP_PUSH_OVF   = 3'd2,  // CALL while full: entry dropped
    OP_POP        = 3'd3,  // RET with something stacked
    OP_POP_UNF    = 3'd4,  // RET while empty
    OP_REPLACE    = 3'd5,  // CALL+RET together on a non-empty stack (tail call)
    OP_PUSH_UNF   = 3'd6   // CALL+RET together while empty: acts as a push
  } stack_op_e;

  // Resolve strobes against current occupancy.
  function automatic stack_op_e decode_op(input logic push,
                                          input logic pop,
                                          input logic empty,
                                          input logic full);
    stack_op_e op;
    case ({push, pop})
      2'b10: begin
        if (full) op = OP_PUSH_OVF;
        else      op = OP_PUSH;
      end
      2'b01: begin
        if (empty) op = OP_POP_UNF;
        else       op = OP_POP;
      end
      2'b11: begin
        if (empty) op = OP_PUSH_UNF;
        else       op = OP_REPLACE;
      end
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pila_retorno_mem.sv
// Return-stack storage: DEPTH x WIDTH, one synchronous write port and one
// combinational read port, built like the register file. No reset: contents
// are only observable through entries below the stack pointer.
module pila_mem
  import pila_retorno_pkg::*;
#(
  parameter int WIDTH = RET_WIDTH,
  parameter int DEPTH = RET_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store wd at wa when we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wa] <= wd;
    end else begin
      mem_r[wa] <= mem_r[wa];
    end
  end

  assign rd = mem_r[ra];

endmodule

// File: rtl/pila_retorno.sv
// Hardware return-address stack for CALL/RET. Owns the stack pointer, the
// sticky error flags and the push/pop decode; storage lives in pila_mem.
module pila_retorno
  import pila_retorno_pkg::*;
#(
  parameter int WIDTH = RET_WIDTH,
  parameter int DEPTH = RET_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // sp is one bit wider than the index so that DEPTH itself is representable;
  // saturation rules keep it from ever wrapping.
  logic [CW-1:0]    sp_r;
  logic             overflow_r;
  logic             underflow_r;

  logic [CW-1:0]    sp_nxt_s;
  logic             set_ovf_s;
  logic             set_unf_s;
  logic             we_s;
  logic             we_gated_s;
  logic [AW-1:0]    wa_s;
  logic [AW-1:0]    ra_s;
  logic [WIDTH-1:0] rd_s;
  logic             empty_s;
  logic             full_s;
  stack_op_e        op_s;

  assign empty_s = (sp_r == {CW{1'b0}});
  assign full_s  = (sp_r == CW'(DEPTH));
  assign op_s    = decode_op(push, pop, empty_s, full_s);

  // Top-of-stack lives one below sp; low bits wrap harmlessly when empty
  // because q is forced to zero then.
  assign ra_s = sp_r[AW-1:0] - AW'(1);

  // Translate the resolved operation into pointer, write and flag controls.
  always_comb begin
    sp_nxt_s  = sp_r;
    set_ovf_s = 1'b0;
    set_unf_s = 1'b0;
    we_s      = 1'b0;
    wa_s      = sp_r[AW-1:0];
    case (op_s)
      OP_PUSH: begin
        we_s     = 1'b1;
        sp_nxt_s = sp_r + CW'(1);
      end
      OP_PUSH_OVF: begin
        set_ovf_s = 1'b1;
      end
      OP_POP: begin
        sp_nxt_s = sp_r - CW'(1);
      end
      OP_POP_UNF: begin
        set_unf_s = 1'b1;
      end
      OP_REPLACE: begin
        we_s = 1'b1;
        wa_s = ra_s;
      end
      OP_PUSH_UNF: begin
        we_s      = 1'b1;
        sp_nxt_s  = sp_r + CW'(1);
        set_unf_s = 1'b1;
      end
      default: begin
        sp_nxt_s = sp_r;
      end
    endcase
  end

  // Reset has priority over any strobe, so no write may slip through with it.
  always_comb begin
    if (reset) begin
      we_gated_s = 1'b0;
    end else begin
      we_gated_s = we_s;
    end
  end

  // Stack pointer and sticky error flags; only reset clears the flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r        <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      sp_r        <= sp_nxt_s;
      overflow_r  <= overflow_r | set_ovf_s;
      underflow_r <= underflow_r | set_unf_s;
    end
  end

  pila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk (clk),
    .we  (we_gated_s),
    .wa  (wa_s),
    .wd  (d),
    .ra  (ra_s),
    .rd  (rd_s)
  );

  // Present zero on q while empty so RET never sees stale storage.
  always_comb begin
    if (empty_s) begin
      q = {WIDTH{1'b0}};
    end else begin
      q = rd_s;
    end
  end

  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = sp_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_pila_retorno.sv
// Self-checking bench for pila_retorno: directed scenarios followed by a
// random push/pop run checked against a queue-based reference stack.
module tb_pila_retorno;

  localparam int W = 10;
  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         push;
  logic         pop;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         empty;
  logic         full;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int stk[$];
  bit m_ovf;
  bit m_unf;

  pila_retorno #(.WIDTH(W), .DEPTH(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .d         (d),
    .q         (q),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference stack by one clock with the given controls.
  task automatic model_step(input bit r, input bit pu, input bit po, input int dv);
    if (r) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (pu && po) begin
      if (stk.size() == 0) begin
        stk.push_back(dv);
        m_unf = 1'b1;
      end else begin
        stk[stk.size()-1] = dv;
      end
    end else if (pu) begin
      if (stk.size() == N) m_ovf = 1'b1;
      else                 stk.push_back(dv);
    end else if (po) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else                 void'(stk.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    int exp_q;
    exp_q = (stk.size() == 0) ? 0 : stk[stk.size()-1];
    chk({tag, ".q"},         32'(q),         32'(exp_q));
    chk({tag, ".count"},     32'(count),     32'(stk.size()));
    chk({tag, ".empty"},     32'(empty),     32'(stk.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(stk.size() == N));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Apply one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input string tag, input bit r, input bit pu, input bit po, input int dv);
    reset = r;
    push  = pu;
    pop   = po;
    d     = W'(dv);
    @(posedge clk);
    model_step(r, pu, po, dv);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    push  = 1'bx;
    pop   = 1'bx;
    d     = 'x;
    // Reset with unknown strobes must still land in the clean reset state.
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0, 0);
    #1;
    check_all("reset_x");
    step("reset", 1'b1, 1'b0, 1'b0, 0);

    // Basic push/pop ordering
    step("push5", 1'b0, 1'b1, 1'b0, 'h005);
    step("pushA", 1'b0, 1'b1, 1'b0, 'h00A);
    step("pushF", 1'b0, 1'b1, 1'b0, 'h00F);
    chk("three.count", 32'(count), 32'd3);
    chk("three.q",     32'(q),     32'h00F);
    step("pop1", 1'b0, 1'b0, 1'b1, 0);
    chk("pop1.q", 32'(q), 32'h00A);
    step("pop2", 1'b0, 1'b0, 1'b1, 0);
    chk("pop2.q", 32'(q), 32'h005);
    step("pop3", 1'b0, 1'b0, 1'b1, 0);
    chk("pop3.q", 32'(q), 32'h000);

    // Fill, overflow, drain
    for (int i = 0; i < N; i++) step("fill", 1'b0, 1'b1, 1'b0, 'h100 + i);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.q",    32'(q),    32'h107);
    step("ovf", 1'b0, 1'b1, 1'b0, 'h3FF);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.q",    32'(q),        32'h107);
    for (int i = 0; i < N; i++) begin
      chk("drain.q", 32'(q), 32'h107 - 32'(i));
      step("drain", 1'b0, 1'b0, 1'b1, 0);
    end

    // Underflow from reset, then normal push
    step("rst2", 1'b1, 1'b0, 1'b0, 0);
    step("unf", 1'b0, 1'b0, 1'b1, 0);
    chk("unf.flag", 32'(underflow), 32'd1);
    step("after_unf", 1'b0, 1'b1, 1'b0, 'h020);
    chk("after_unf.q", 32'(q), 32'h020);

    // Tail call
    step("rst3", 1'b1, 1'b0, 1'b0, 0);
    step("tc_push", 1'b0, 1'b1, 1'b0, 'h011);
    step("tc_both", 1'b0, 1'b1, 1'b1, 'h022);
    chk("tc.q", 32'(q), 32'h022);
    step("tc_pop", 1'b0, 1'b0, 1'b1, 0);

    // Push+pop while empty acts as push and flags underflow; while full replaces top
    step("pp_empty", 1'b0, 1'b1, 1'b1, 'h0AB);
    for (int i = 0; i < N - 1; i++) step("refill", 1'b0, 1'b1, 1'b0, 'h200 + i);
    step("pp_full", 1'b0, 1'b1, 1'b1, 'h155);
    chk("pp_full.ovf", 32'(overflow), 32'd0);

    // Reset while pushing with an error flag set
    step("rst4", 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N + 1; i++) step("ovf2", 1'b0, 1'b1, 1'b0, 'h050 + i);
    step("rst_push", 1'b1, 1'b1, 1'b0, 'h3AA);
    chk("rst_push.count", 32'(count), 32'd0);

    // Random run
    for (int i = 0; i < 500; i++) begin
      bit r;
      r = ($urandom_range(0, 59) == 0);
      step("rand", r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
